// File: rtl/pck_sink_checker_pkg.sv
// Shared types and traffic-pattern defaults for the receive-side packet checker.
// The pattern is data = BASE + seq, size = MIN_SIZE + (seq mod SIZE_MOD),
// with seq tracked per source endpoint.
package pck_sink_checker_pkg;

  localparam int PCK_NEW    = 4;
  localparam int PCK_DATA_W = 128;
  localparam int PCK_SIZE_W = 8;

  localparam logic [PCK_DATA_W-1:0] PCK_BASE = 128'h0123456789ABCDEFEDCBA987654321;
  localparam int PCK_MIN_SIZE = 3;
  localparam int PCK_SIZE_MOD = 18;
  localparam int PCK_SEQ_STEP = 2;

  // Per-source expectation: running seq and its size offset (seq mod SIZE_MOD).
  typedef struct packed {
    logic [PCK_DATA_W-1:0] seq;
    logic [PCK_SIZE_W-1:0] size_off;
  } pck_chk_entry_t;

  // First-error capture record.
  typedef struct packed {
    logic                  valid;
    logic [PCK_NEW-1:0]    src;
    logic [PCK_DATA_W-1:0] exp_data;
    logic [PCK_DATA_W-1:0] got_data;
  } pck_chk_err_t;

  // Advance one entry by step. size_off is kept in 0..modulus-1 with a
  // single conditional subtract, which is valid because step < modulus.
  function automatic pck_chk_entry_t pck_chk_advance(input pck_chk_entry_t cur,
                                                     input int step,
                                                     input int modulus);
    pck_chk_entry_t      nxt;
    logic [PCK_SIZE_W:0] off;
    nxt.seq = cur.seq + PCK_DATA_W'(step);
    off     = {1'b0, cur.size_off} + (PCK_SIZE_W+1)'(step);
    if (off >= (PCK_SIZE_W+1)'(modulus)) off = off - (PCK_SIZE_W+1)'(modulus);
    nxt.size_off = off[PCK_SIZE_W-1:0];
    return nxt;
  endfunction

endpackage

// File: rtl/pck_chk_seq_table.sv
// Per-source sequence table: NE entries, one combinational read port, one
// write port, and write-to-read forwarding so a read in the same cycle as a
// write to the same index sees the new value.
module pck_chk_seq_table
  import pck_sink_checker_pkg::*;
#(
  parameter int NE  = 16,
  parameter int NEw = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NEw-1:0] rd_idx,
  output pck_chk_entry_t rd_entry,
  input  logic           wr_en,
  input  logic [NEw-1:0] wr_idx,
  input  pck_chk_entry_t wr_entry
);

  pck_chk_entry_t mem [NE];

  // Storage: cleared on reset, written with the updated entry of each checked packet.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: this table is cleared on reset because every source's sequence
      // must restart at 0; that keeps it in flops rather than an inferred RAM.
      for (int i = 0; i < NE; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_entry;
    end
  end

  // Read with bypass of the entry being written this cycle.
  always_comb begin
    // NOTE: rd_entry is assigned before any condition so no path leaves it
    // unassigned, which would otherwise infer a latch.
    rd_entry = mem[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) rd_entry = wr_entry;
  end

endmodule

// File: rtl/pck_sink_checker.sv
// Receive-side checker for the packet-injector control interface.
// Two-stage pipeline: stage 1 registers the report and reads the per-source
// table, stage 2 compares against the expected pattern and writes the table.
// chk_ok/chk_err pulse two cycles after the accepting edge.
// Optional idle timeout: define PCK_CHK_TIMEOUT_EN.
module pck_sink_checker
  import pck_sink_checker_pkg::*;
#(
  parameter int                NE       = 16,
  parameter int                NEw      = PCK_NEW,
  parameter int                DATA_W   = PCK_DATA_W,
  parameter int                SIZE_W   = PCK_SIZE_W,
  parameter logic [DATA_W-1:0] BASE     = DATA_W'(PCK_BASE),
  parameter int                SEQ_STEP = PCK_SEQ_STEP,
  parameter int                MIN_SIZE = PCK_MIN_SIZE,
  parameter int                SIZE_MOD = PCK_SIZE_MOD,
  parameter int                CNT_W    = 32,
  parameter int                TIMEOUT  = 10000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chk_en,
  input  logic              rx_wr,
  input  logic [NEw-1:0]    rx_src,
  input  logic [SIZE_W-1:0] rx_size,
  input  logic [DATA_W-1:0] rx_data,
  output logic              chk_ok,
  output logic              chk_err,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_valid,
  output logic [NEw-1:0]    err_src,
  output logic [DATA_W-1:0] err_exp_data,
  output logic [DATA_W-1:0] err_got_data,
  output logic              timeout
);

  logic accept;
  assign accept = rx_wr && chk_en;

  // Stage 1 registers.
  logic              s1_valid;
  logic [NEw-1:0]    s1_src;
  logic [SIZE_W-1:0] s1_size;
  logic [DATA_W-1:0] s1_data;
  logic              s1_in_range;

  // Stage 2 registers.
  logic              s2_valid;
  logic              s2_in_range;
  logic [NEw-1:0]    s2_src;
  logic [SIZE_W-1:0] s2_size;
  logic [DATA_W-1:0] s2_data;
  pck_chk_entry_t    s2_entry;

  pck_chk_entry_t    rd_entry;
  pck_chk_entry_t    upd_entry;
  logic [DATA_W-1:0] exp_data;
  logic [SIZE_W-1:0] exp_size;
  logic              match;
  logic              table_wr;
  pck_chk_err_t      err_q;

  // Sources at or beyond NE have no table entry.
  assign s1_in_range = ({1'b0, s1_src} < (NEw+1)'(NE));

  pck_chk_seq_table #(
    .NE  (NE),
    .NEw (NEw)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (s1_src),
    .rd_entry (rd_entry),
    .wr_en    (table_wr),
    .wr_idx   (s2_src),
    .wr_entry (upd_entry)
  );

  // Stage 1: capture an accepted report.
  always_ff @(posedge clk) begin
    // NOTE: pipeline state uses <= so every flop samples pre-edge values;
    // blocking assignments would let stage 2 see this edge's stage-1 update.
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_src   <= '0;
      s1_size  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_src  <= rx_src;
        s1_size <= rx_size;
        s1_data <= rx_data;
      end
    end
  end

  // Stage 2: hold the report with its (forwarded) table entry for comparison.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_valid    <= 1'b0;
      s2_in_range <= 1'b0;
      s2_src      <= '0;
      s2_size     <= '0;
      s2_data     <= '0;
      s2_entry    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_in_range <= s1_in_range;
        s2_src      <= s1_src;
        s2_size     <= s1_size;
        s2_data     <= s1_data;
        s2_entry    <= rd_entry;
      end
    end
  end

  // Compare and next-entry computation. The table advances on mismatch too,
  // so one corrupted packet does not cascade into later errors.
  assign exp_data  = s2_in_range ? (BASE + s2_entry.seq) : '0;
  assign exp_size  = SIZE_W'(MIN_SIZE) + s2_entry.size_off;
  assign match     = s2_in_range && (s2_data == exp_data) && (s2_size == exp_size);
  assign upd_entry = pck_chk_advance(s2_entry, SEQ_STEP, SIZE_MOD);
  assign table_wr  = s2_valid && s2_in_range;

  // Result pulses, saturating counters and sticky first-error capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chk_ok  <= 1'b0;
      chk_err <= 1'b0;
      pkt_cnt <= '0;
      err_cnt <= '0;
      err_q   <= '0;
    end else begin
      chk_ok  <= s2_valid && match;
      chk_err <= s2_valid && !match;
      if (s2_valid && (pkt_cnt != '1)) pkt_cnt <= pkt_cnt + CNT_W'(1);
      if (s2_valid && !match && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      if (s2_valid && !match && !err_q.valid) begin
        err_q.valid    <= 1'b1;
        err_q.src      <= s2_src;
        err_q.exp_data <= exp_data;
        err_q.got_data <= s2_data;
      end
    end
  end

  assign err_valid    = err_q.valid;
  assign err_src      = err_q.src;
  assign err_exp_data = err_q.exp_data;
  assign err_got_data = err_q.got_data;

`ifdef PCK_CHK_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout_q;

  // Idle watchdog: cleared by accepted reports, counts while checking is enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        idle_cnt <= '0;
      end else if (chk_en && (idle_cnt != IDLE_W'(TIMEOUT))) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
        if (idle_cnt == IDLE_W'(TIMEOUT - 1)) timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  // Watchdog compiled out; this is constant 0 for any legal TIMEOUT.
  assign timeout = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_pck_sink_checker.sv
// Directed bench for pck_sink_checker with a scoreboard of expected pulses.
// Define PCK_CHK_TIMEOUT_EN to also exercise the idle watchdog.
module tb_pck_sink_checker;

  localparam logic [127:0] BASE     = 128'h0123456789ABCDEFEDCBA987654321;
  localparam int           MIN_SIZE = 3;
  localparam int           SIZE_MOD = 18;
  localparam int           SEQ_STEP = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         chk_en = 1'b0;
  logic         rx_wr = 1'b0;
  logic [3:0]   rx_src = '0;
  logic [7:0]   rx_size = '0;
  logic [127:0] rx_data = '0;
  logic         chk_ok, chk_err, err_valid, timeout;
  logic [31:0]  pkt_cnt, err_cnt;
  logic [3:0]   err_src;
  logic [127:0] err_exp_data, err_got_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic ok;
    int   due;
  } exp_t;
  exp_t sb[$];

  logic [127:0] m_seq [16];
  int           m_off [16];
  int           exp_pkt, exp_err;
  logic         drop = 1'b0;
  logic         mon_en = 1'b0;

  pck_sink_checker #(.TIMEOUT(50)) dut (
    .clk          (clk),
    .reset        (reset),
    .chk_en       (chk_en),
    .rx_wr        (rx_wr),
    .rx_src       (rx_src),
    .rx_size      (rx_size),
    .rx_data      (rx_data),
    .chk_ok       (chk_ok),
    .chk_err      (chk_err),
    .pkt_cnt      (pkt_cnt),
    .err_cnt      (err_cnt),
    .err_valid    (err_valid),
    .err_src      (err_src),
    .err_exp_data (err_exp_data),
    .err_got_data (err_got_data),
    .timeout      (timeout)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every negedge either a due entry is matched or no pulse is allowed.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("pulse_ok", chk_ok, sb[0].ok);
        check("pulse_err", chk_err, !sb[0].ok);
        void'(sb.pop_front());
      end else begin
        check("no_pulse", {chk_ok, chk_err}, 2'b00);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_seq[i] = '0;
      m_off[i] = 0;
    end
    exp_pkt = 0;
    exp_err = 0;
  endtask

  task automatic drive(input int src, input logic [127:0] data, input int size);
    exp_t e;
    @(posedge clk); #1;
    rx_wr   = 1'b1;
    rx_src  = 4'(src);
    rx_size = 8'(size);
    rx_data = data;
    if (chk_en && reset && !drop) begin
      e.ok  = (data == BASE + m_seq[src]) && (size == MIN_SIZE + m_off[src]);
      e.due = cyc + 3;
      sb.push_back(e);
      m_seq[src] = m_seq[src] + SEQ_STEP;
      m_off[src] = (m_off[src] + SEQ_STEP) % SIZE_MOD;
      exp_pkt++;
      if (!e.ok) exp_err++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_wr = 1'b0;
    end
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    check({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
  endtask

  task automatic check_cleared(input string tag);
    @(negedge clk);
    check({tag, "_chk_ok"}, chk_ok, 0);
    check({tag, "_chk_err"}, chk_err, 0);
    check({tag, "_pkt_cnt"}, pkt_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_err_valid"}, err_valid, 0);
    check({tag, "_err_src"}, err_src, 0);
    check({tag, "_err_exp"}, err_exp_data, 0);
    check({tag, "_err_got"}, err_got_data, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    model_reset();
    mon_en = 1'b1;
    idle(3);
    check_cleared("reset");

    @(posedge clk); #1;
    reset  = 1'b1;
    chk_en = 1'b1;

    // Src 0: seq 0, 2, 4 with gaps.
    for (int i = 0; i < 3; i++) begin
      drive(0, BASE + 128'(2 * i), MIN_SIZE + 2 * i);
      idle(2);
    end
    idle(3);
    check_counts("src0");
    check("src0_pkt_lit", pkt_cnt, 3);

    // Src 1: 12 back-to-back packets, size offset wraps 16 -> 0.
    for (int i = 0; i < 12; i++) drive(1, BASE + 128'(2 * i), MIN_SIZE + ((2 * i) % SIZE_MOD));
    idle(4);
    check_counts("src1_wrap");

    // Src 2: corrupted second packet, third recovers.
    drive(2, BASE, 3);
    drive(2, BASE + 3, 5);
    drive(2, BASE + 4, 7);
    idle(4);
    check_counts("src2");
    check("cap_valid", err_valid, 1);
    check("cap_src", err_src, 2);
    check("cap_exp", err_exp_data, BASE + 2);
    check("cap_got", err_got_data, BASE + 3);

    // Forwarding: same source twice in a row, then another source, then src 0 pair.
    drive(5, BASE, 3);
    drive(5, BASE + 2, 5);
    drive(6, BASE, 3);
    drive(0, BASE + 6, 9);
    drive(0, BASE + 8, 11);
    idle(4);
    check_counts("fwd");

    // Second error (wrong size) must not disturb the first capture.
    drive(3, BASE, 4);
    idle(4);
    check_counts("err2");
    check("cap_hold_src", err_src, 2);
    check("cap_hold_got", err_got_data, BASE + 3);

    // Disabled: reports ignored, table frozen.
    chk_en = 1'b0;
    drive(0, BASE + 99, 1);
    drive(0, BASE + 10, 13);
    idle(4);
    check_counts("disabled");
    chk_en = 1'b1;
    drive(0, BASE + 10, 13);
    idle(4);
    check_counts("reenabled");

    // Reset with a packet in flight: it is dropped.
    drop = 1'b1;
    drive(4, BASE, 3);
    @(posedge clk); #1;
    reset = 1'b0;
    rx_wr = 1'b0;
    idle(2);
    check_cleared("midreset");
    @(posedge clk); #1;
    reset = 1'b1;
    drop  = 1'b0;
    model_reset();
    drive(0, BASE, 3);
    idle(4);
    check_counts("post_reset");
    check("post_reset_err_valid", err_valid, 0);

`ifdef PCK_CHK_TIMEOUT_EN
    idle(40);
    @(negedge clk);
    check("timeout_early", timeout, 0);
    idle(20);
    @(negedge clk);
    check("timeout_set", timeout, 1);
`else
    idle(60);
    @(negedge clk);
    check("timeout_off", timeout, 0);
`endif

    check("sb_drained", sb.size(), 0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
